cim_weight_loader: RTL and testbench
====================================

Name: cim_weight_loader

Overview:
Initiator-side controller for the dual-core ping-pong CIM unit's standard-access (STD) port. It accepts a 288-bit weight row stream over a valid/ready handshake and writes 64 rows into the standby core with STDW. On request it swaps the core-select so the freshly loaded core becomes the compute core. It also serves single-row STDR readbacks from the standby core. It sits between the weight buffer/DMA and the CIM unit and owns CIM_Core_A.

Parameters:
ROWS, 64, rows per core
ROW_W, 6, row address width (log2 ROWS)
DATA_W, 288, weight row width (4b x 8 x 9)
RD_LAT, 1, cycles from STDR assertion to valid weight_out (1..3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
wt_valid  in  1  upstream weight row valid
wt_data  in  DATA_W  upstream weight row
wt_ready  out  1  loader accepts row this cycle
swap_ok  in  1  compute side permits core swap
flush  in  1  synchronous abort of partial load
rd_req  in  1  readback request
rd_row  in  ROW_W  readback row
rd_ready  out  1  readback request accepted this cycle
rd_valid  out  1  readback data valid (1-cycle pulse)
rd_data  out  DATA_W  readback data
bank_ready  out  1  standby core fully loaded, awaiting swap
CIM_Core_A  out  1  compute core select to CIM unit
STDW  out  1  standard write strobe
STDR  out  1  standard read strobe
STD_en  out  1  STDW | STDR
STD_row_A  out  ROW_W  STD row address
weight_in  out  DATA_W  write data to CIM unit
weight_out  in  DATA_W  read data from CIM unit

Behaviour:
- Reset (async, rst=1): state IDLE, row counter 0, CIM_Core_A=0, STDW=STDR=STD_en=0, STD_row_A=0, weight_in=0, rd_valid=0, rd_data=0, bank_ready=0, wt_ready=0, rd_ready=0. Reset during a load discards the partial load; the standby core contents are undefined.
- All outputs to the CIM unit are registered.
- States: IDLE, WRITE, LOADED, READ, SWAP.
- IDLE: wt_ready=1 and rd_ready=1 only when rd_req=0. If rd_req=1, it is accepted first (read priority) and the state goes to READ. Otherwise a wt_valid&wt_ready handshake captures the row and the state goes to WRITE.
- WRITE: each handshake registers STDW=1, STD_row_A=counter, weight_in=wt_data on the next cycle; the counter increments. wt_ready=1 continuously (back-to-back rows, one per cycle); bubbles give STDW=0. rd_ready=0.
- The handshake at counter=ROWS-1 goes to LOADED. The counter wraps to 0 and bank_ready=1 from the cycle after the final STDW.
- LOADED: wt_ready=0. swap_ok=1 goes to SWAP. rd_req is accepted (rd_ready=1) only if swap_ok=0 (swap wins); it goes to READ and returns to LOADED.
- SWAP (1 cycle): CIM_Core_A toggles, bank_ready clears, then IDLE.
- READ: STDR=1 with STD_row_A=rd_row (registered) for exactly one cycle. weight_out is sampled RD_LAT cycles after STDR rises and driven to rd_data with rd_valid=1 for one cycle. The state then returns to its origin (IDLE or LOADED). No new request is accepted while a read is in flight.
- STDW and STDR are never asserted together. STD_en=STDW|STDR.
- flush=1: in WRITE it drops to IDLE with counter=0 and the in-flight STDW completes. In LOADED it clears bank_ready and goes to IDLE. In IDLE/READ/SWAP it is ignored. CIM_Core_A is never changed by flush.
- swap_ok outside LOADED is ignored; there is no swap without a full load.

Decomposition:
- Shared package cim_pkg: DATA_W, ROWS, ROW_W constants, the state enum, and PSUM/weight width constants reused by CIM_Unit.
- One sub-module, cim_rd_pipe: RD_LAT-deep valid shift register plus the capture register for weight_out.

Test Plan:
- Back-to-back load: 64 rows with data = row index replicated, wt_valid held high -> STDW high 64 consecutive cycles, STD_row_A 0..63, bank_ready=1 the cycle after row 63, CIM_Core_A still 0.
- Bubbled load plus swap: random wt_valid gaps, then swap_ok pulse -> no STDW on gap cycles; CIM_Core_A toggles to 1 one cycle after the swap, bank_ready drops, state IDLE.
- Readback: after loading, rd_req with rd_row=37 and RD_LAT=2 -> one-cycle STDR with STD_row_A=37, rd_valid 2 cycles later, rd_data = model's weight_out for row 37.
- Collisions: rd_req with wt_valid in IDLE -> read first and wt_ready=0 until done. swap_ok with rd_req in LOADED -> swap taken, rd_ready=0.
- Flush at row 20 -> IDLE. A fresh load then starts at STD_row_A=0 and CIM_Core_A is unchanged.
- Async rst asserted mid-WRITE at row 10 -> all outputs 0 immediately (no clock edge needed), CIM_Core_A=0, and the next load starts at row 0.

Source files
------------

// File: rtl/cim_pkg.sv
// Shared constants and types for the CIM weight path (loader and CIM_Unit).
// Latency: n/a (package only).
// Backpressure: n/a.
package cim_pkg;

  // Geometry of one CIM core: 64 rows of 8 columns x 9 groups of 4-bit weights.
  localparam int ROWS     = 64;
  localparam int ROW_W    = 6;
  localparam int WGT_W    = 4;
  localparam int WGT_COLS = 8;
  localparam int WGT_GRP  = 9;
  localparam int DATA_W   = WGT_W * WGT_COLS * WGT_GRP;

  // Partial sum width: a 4b x 4b product accumulated over all rows.
  localparam int PSUM_W   = 2 * WGT_W + ROW_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_LOADED,
    ST_READ,
    ST_SWAP
  } ld_state_e;

endpackage

// File: rtl/cim_rd_pipe.sv
// Readback return pipe: tracks an STDR strobe and captures weight_out when it is due.
// Latency: rd_valid_o/rd_data_o appear RD_LAT cycles after stdr_i is seen high.
// Backpressure: none; one capture per strobe, the caller keeps strobes apart.
// Ports: clk/rst; stdr_i registered read strobe; weight_out_i CIM read data;
//        rd_valid_o one-cycle data-valid pulse; rd_data_o captured row.
module cim_rd_pipe
  import cim_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stdr_i,
  input  logic [DATA_W-1:0] weight_out_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] rd_data_q;
  // tap[k] is high k cycles after the strobe; tap[0] is the strobe itself, so
  // the capture enable tap[RD_LAT-1] lines up with the edge that fills tap[RD_LAT].
  logic [RD_LAT:0]   tap;

  assign tap = {vld_q, stdr_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      rd_data_q <= '0;
    end else begin
      vld_q <= tap[RD_LAT-1:0];
      if (tap[RD_LAT-1]) begin
        rd_data_q <= weight_out_i;
      end
    end
  end

  assign rd_valid_o = tap[RD_LAT];
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/cim_weight_loader.sv
// Loads 64 weight rows into the standby CIM core over STDW, swaps cores, serves STDR readbacks.
// Latency: accepted row -> STDW next cycle; read accept -> STDR next cycle -> rd_valid RD_LAT later.
// Backpressure: wt_ready/rd_ready low outside IDLE/WRITE resp. IDLE/LOADED; reads win over rows.
// Ports: wt_* upstream row stream; swap_ok/flush control; rd_* readback; bank_ready load done;
//        CIM_Core_A, STDW, STDR, STD_en, STD_row_A, weight_in registered to CIM; weight_out back.
module cim_weight_loader
  import cim_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wt_valid,
  input  logic [DATA_W-1:0] wt_data,
  output logic              wt_ready,
  input  logic              swap_ok,
  input  logic              flush,
  input  logic              rd_req,
  input  logic [ROW_W-1:0]  rd_row,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              bank_ready,
  output logic              CIM_Core_A,
  output logic              STDW,
  output logic              STDR,
  output logic              STD_en,
  output logic [ROW_W-1:0]  STD_row_A,
  output logic [DATA_W-1:0] weight_in,
  input  logic [DATA_W-1:0] weight_out
);

  ld_state_e         state_q, state_d;
  logic [ROW_W-1:0]  cnt_q, cnt_d;
  logic              org_q, org_d;      // read launched from LOADED
  logic              stdw_q, stdw_d;
  logic              stdr_q, stdr_d;
  logic              std_en_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0] win_q, win_d;
  logic              core_q, core_d;
  logic              bank_q, bank_d;
  logic              wt_rdy_c, rd_rdy_c;
  logic              pipe_vld;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    org_d    = org_q;
    stdw_d   = 1'b0;
    stdr_d   = 1'b0;
    row_d    = row_q;
    win_d    = win_q;
    core_d   = core_q;
    bank_d   = bank_q;
    wt_rdy_c = 1'b0;
    rd_rdy_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rd_rdy_c = 1'b1;
        wt_rdy_c = ~rd_req;
        if (rd_req) begin
          stdr_d  = 1'b1;
          row_d   = rd_row;
          org_d   = 1'b0;
          state_d = ST_READ;
        end else if (wt_valid) begin
          // Counter is always 0 here, so this is row 0 of a new load.
          stdw_d  = 1'b1;
          row_d   = cnt_q;
          win_d   = wt_data;
          cnt_d   = cnt_q + ROW_W'(1);
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (flush) begin
          // Aborting load: accept nothing more; an STDW already registered still goes out.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          wt_rdy_c = 1'b1;
          if (wt_valid) begin
            stdw_d = 1'b1;
            row_d  = cnt_q;
            win_d  = wt_data;
            if (cnt_q == ROW_W'(ROWS - 1)) begin
              cnt_d   = '0;
              state_d = ST_LOADED;
            end else begin
              cnt_d = cnt_q + ROW_W'(1);
            end
          end
        end
      end

      ST_LOADED: begin
        if (flush) begin
          bank_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          // Raising here puts bank_ready one cycle after the final STDW.
          bank_d = 1'b1;
          if (swap_ok) begin
            state_d = ST_SWAP;
          end else begin
            rd_rdy_c = 1'b1;
            if (rd_req) begin
              stdr_d  = 1'b1;
              row_d   = rd_row;
              org_d   = 1'b1;
              state_d = ST_READ;
            end
          end
        end
      end

      ST_READ: begin
        if (pipe_vld) begin
          state_d = org_q ? ST_LOADED : ST_IDLE;
        end
      end

      ST_SWAP: begin
        core_d  = ~core_q;
        bank_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      org_q    <= 1'b0;
      stdw_q   <= 1'b0;
      stdr_q   <= 1'b0;
      std_en_q <= 1'b0;
      row_q    <= '0;
      win_q    <= '0;
      core_q   <= 1'b0;
      bank_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      org_q    <= org_d;
      stdw_q   <= stdw_d;
      stdr_q   <= stdr_d;
      std_en_q <= stdw_d | stdr_d;
      row_q    <= row_d;
      win_q    <= win_d;
      core_q   <= core_d;
      bank_q   <= bank_d;
    end
  end

  cim_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk          (clk),
    .rst          (rst),
    .stdr_i       (stdr_q),
    .weight_out_i (weight_out),
    .rd_valid_o   (pipe_vld),
    .rd_data_o    (rd_data)
  );

  // Ready terms are combinational; hold them low while reset is applied.
  assign wt_ready   = wt_rdy_c & ~rst;
  assign rd_ready   = rd_rdy_c & ~rst;
  assign rd_valid   = pipe_vld;
  assign bank_ready = bank_q;
  assign CIM_Core_A = core_q;
  assign STDW       = stdw_q;
  assign STDR       = stdr_q;
  assign STD_en     = std_en_q;
  assign STD_row_A  = row_q;
  assign weight_in  = win_q;

endmodule

// File: tb/tb_cim_weight_loader.sv
// Bench for cim_weight_loader with a two-core CIM memory model and write/read scoreboards.
// Latency: model returns weight_out one cycle after STDR (RD_LAT=2 from strobe to rd_valid).
// Backpressure: rows and reads are only pushed to the scoreboard on a seen handshake.
module tb_cim_weight_loader;
  import cim_pkg::*;

  localparam int RD_LAT = 2;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] dat;
  } wexp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              wt_valid, wt_ready, swap_ok, flush, rd_req, rd_ready, rd_valid;
  logic [DATA_W-1:0] wt_data, rd_data, weight_in, weight_out;
  logic [ROW_W-1:0]  rd_row, STD_row_A;
  logic              bank_ready, CIM_Core_A, STDW, STDR, STD_en;

  always #5 clk = ~clk;

  cim_weight_loader #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
    .swap_ok(swap_ok), .flush(flush), .rd_req(rd_req), .rd_row(rd_row),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .bank_ready(bank_ready),
    .CIM_Core_A(CIM_Core_A), .STDW(STDW), .STDR(STDR), .STD_en(STD_en),
    .STD_row_A(STD_row_A), .weight_in(weight_in), .weight_out(weight_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // CIM memory model: writes land in the standby core, reads return one cycle after STDR.
  logic [DATA_W-1:0] mem [2][ROWS];
  logic              rdp_v = 1'b0;
  logic [ROW_W-1:0]  rdp_row = '0;
  logic              rdp_core = 1'b0;

  always @(posedge clk) begin
    if (STDW) mem[~CIM_Core_A][STD_row_A] <= weight_in;
    rdp_v    <= STDR;
    rdp_row  <= STD_row_A;
    rdp_core <= ~CIM_Core_A;
  end

  assign weight_out = rdp_v ? mem[rdp_core][rdp_row] : {9{32'hBADC0FFE}};

  // Scoreboards and bench-side expectation of core contents.
  wexp_t             wq[$];
  logic [ROW_W-1:0]  sq[$];
  logic [DATA_W-1:0] rq[$];
  logic [DATA_W-1:0] exp_mem [2][ROWS];
  logic              exp_core_a = 1'b0;

  int   cyc = 0;
  int   stdr_cyc = 0, last_stdw_cyc = 0, run = 0, max_run = 0;
  logic bank_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (STDW) begin
        wexp_t e;
        check_eq("stdw_excl", DATA_W'(STDR), DATA_W'(0));
        check_eq("stdw_en", DATA_W'(STD_en), DATA_W'(1));
        if (wq.size() == 0) begin
          check_eq("stdw_unexp", DATA_W'(STDW), DATA_W'(0));
        end else begin
          e = wq.pop_front();
          check_eq("stdw_row", DATA_W'(STD_row_A), DATA_W'(e.row));
          check_eq("stdw_dat", weight_in, e.dat);
        end
        run++;
        last_stdw_cyc = cyc;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (STDR) begin
        check_eq("stdr_en", DATA_W'(STD_en), DATA_W'(1));
        if (sq.size() == 0) check_eq("stdr_unexp", DATA_W'(STDR), DATA_W'(0));
        else check_eq("stdr_row", DATA_W'(STD_row_A), DATA_W'(sq.pop_front()));
        stdr_cyc = cyc;
      end
      if (rd_valid) begin
        check_eq("rd_lat", DATA_W'(cyc - stdr_cyc), DATA_W'(RD_LAT));
        if (rq.size() == 0) check_eq("rd_unexp", DATA_W'(rd_valid), DATA_W'(0));
        else check_eq("rd_data", rd_data, rq.pop_front());
      end
      if (bank_ready && !bank_prev)
        check_eq("bank_rise", DATA_W'(cyc - last_stdw_cyc), DATA_W'(1));
      bank_prev = bank_ready;
    end
  end

  function automatic logic [DATA_W-1:0] pat(input int r, input logic [7:0] salt);
    logic [7:0] b;
    b = 8'(r) ^ salt;
    return {36{b}};
  endfunction

  // Streams n rows starting at row 0; gap_pct inserts random idle cycles.
  task automatic send_rows(input int n, input logic [7:0] salt, input int gap_pct);
    logic [DATA_W-1:0] d;
    int k;
    for (int r = 0; r < n; r++) begin
      d = pat(r, salt);
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        wt_valid = 1'b0;
        @(posedge clk); #1;
      end
      wt_valid = 1'b1;
      wt_data  = d;
      k = 0;
      @(negedge clk);
      while (!wt_ready && k < 40) begin
        @(negedge clk);
        k++;
      end
      check_eq("wt_hs", DATA_W'(wt_ready), DATA_W'(1));
      wq.push_back('{row: ROW_W'(r), dat: d});
      exp_mem[~exp_core_a][r] = d;
      @(posedge clk); #1;
    end
    wt_valid = 1'b0;
  endtask

  task automatic do_read(input int row);
    int k;
    rd_req = 1'b1;
    rd_row = ROW_W'(row);
    k = 0;
    @(negedge clk);
    while (!rd_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check_eq("rd_acc", DATA_W'(rd_ready), DATA_W'(1));
    rq.push_back(exp_mem[~exp_core_a][row]);
    sq.push_back(ROW_W'(row));
    @(posedge clk); #1;
    rd_req = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rd_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("rd_done", DATA_W'(rd_valid), DATA_W'(1));
    @(posedge clk); #1;
  endtask

  // Swap from LOADED; with_rd also raises a colliding readback that must be refused.
  task automatic do_swap(input logic with_rd);
    swap_ok = 1'b1;
    if (with_rd) begin
      rd_req = 1'b1;
      rd_row = ROW_W'(3);
    end
    #1;
    if (with_rd) check_eq("swap_rd_rdy", DATA_W'(rd_ready), DATA_W'(0));
    @(posedge clk); #1;
    swap_ok = 1'b0;
    rd_req  = 1'b0;
    check_eq("swap_core_hold", DATA_W'(CIM_Core_A), DATA_W'(exp_core_a));
    @(posedge clk); #1;
    exp_core_a = ~exp_core_a;
    check_eq("swap_core", DATA_W'(CIM_Core_A), DATA_W'(exp_core_a));
    check_eq("swap_bank", DATA_W'(bank_ready), DATA_W'(0));
    check_eq("swap_idle", DATA_W'(wt_ready), DATA_W'(1));
  endtask

  task automatic check_reset_outs(input string p);
    check_eq({p, "_wt_rdy"}, DATA_W'(wt_ready), DATA_W'(0));
    check_eq({p, "_rd_rdy"}, DATA_W'(rd_ready), DATA_W'(0));
    check_eq({p, "_stdw"}, DATA_W'(STDW), DATA_W'(0));
    check_eq({p, "_stdr"}, DATA_W'(STDR), DATA_W'(0));
    check_eq({p, "_std_en"}, DATA_W'(STD_en), DATA_W'(0));
    check_eq({p, "_row"}, DATA_W'(STD_row_A), DATA_W'(0));
    check_eq({p, "_win"}, weight_in, DATA_W'(0));
    check_eq({p, "_rd_vld"}, DATA_W'(rd_valid), DATA_W'(0));
    check_eq({p, "_rd_dat"}, rd_data, DATA_W'(0));
    check_eq({p, "_bank"}, DATA_W'(bank_ready), DATA_W'(0));
    check_eq({p, "_core"}, DATA_W'(CIM_Core_A), DATA_W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; wt_valid = 1'b1; wt_data = '1; swap_ok = 1'b0; flush = 1'b0;
    rd_req = 1'b0; rd_row = '0;
    #12;
    check_reset_outs("rst");
    wt_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("idle_wt_rdy", DATA_W'(wt_ready), DATA_W'(1));
    check_eq("idle_rd_rdy", DATA_W'(rd_ready), DATA_W'(1));

    // Back-to-back full load.
    max_run = 0;
    send_rows(64, 8'h00, 0);
    check_eq("loaded_wt_rdy", DATA_W'(wt_ready), DATA_W'(0));
    @(posedge clk); #1;
    check_eq("b2b_run", DATA_W'(max_run), DATA_W'(64));
    check_eq("b2b_bank", DATA_W'(bank_ready), DATA_W'(1));
    check_eq("b2b_core", DATA_W'(CIM_Core_A), DATA_W'(0));

    // Readback from LOADED, then swap that beats a colliding read.
    do_read(37);
    check_eq("rd_keep_bank", DATA_W'(bank_ready), DATA_W'(1));
    check_eq("rd_back_loaded", DATA_W'(wt_ready), DATA_W'(0));
    do_swap(1'b1);

    // Bubbled load into the other core, boundary readback, plain swap.
    send_rows(64, 8'h5A, 30);
    @(posedge clk); #1;
    check_eq("bub_bank", DATA_W'(bank_ready), DATA_W'(1));
    do_read(0);
    do_swap(1'b0);

    // Read wins over a simultaneous row in IDLE; rows stay blocked until the read returns.
    wt_valid = 1'b1;
    wt_data  = pat(0, 8'h99);
    rd_req   = 1'b1;
    rd_row   = ROW_W'(12);
    #1;
    check_eq("col_wt_rdy", DATA_W'(wt_ready), DATA_W'(0));
    check_eq("col_rd_rdy", DATA_W'(rd_ready), DATA_W'(1));
    rq.push_back(exp_mem[~exp_core_a][12]);
    sq.push_back(ROW_W'(12));
    @(posedge clk); #1;
    rd_req = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rd_valid && k < 20) begin
      check_eq("col_busy_wt_rdy", DATA_W'(wt_ready), DATA_W'(0));
      @(negedge clk);
      k++;
    end
    check_eq("col_rd_done", DATA_W'(rd_valid), DATA_W'(1));
    @(posedge clk); #1;
    wt_valid = 1'b0;

    // Flush after 20 rows, then a fresh full load restarts at row 0.
    send_rows(20, 8'h33, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_idle", DATA_W'(wt_ready), DATA_W'(1));
    check_eq("flush_bank", DATA_W'(bank_ready), DATA_W'(0));
    check_eq("flush_core", DATA_W'(CIM_Core_A), DATA_W'(exp_core_a));
    check_eq("flush_drain", DATA_W'(wq.size()), DATA_W'(0));
    send_rows(64, 8'hC3, 0);
    @(posedge clk); #1;
    check_eq("reload_bank", DATA_W'(bank_ready), DATA_W'(1));
    check_eq("reload_core", DATA_W'(CIM_Core_A), DATA_W'(0));
    do_swap(1'b0);

    // Async reset in the middle of a load, away from any clock edge.
    send_rows(10, 8'h77, 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outs("arst");
    wq.delete();
    exp_core_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    send_rows(64, 8'hE1, 0);
    @(posedge clk); #1;
    check_eq("post_rst_bank", DATA_W'(bank_ready), DATA_W'(1));
    do_read(63);

    repeat (3) @(posedge clk);
    #1;
    check_eq("end_wq", DATA_W'(wq.size()), DATA_W'(0));
    check_eq("end_sq", DATA_W'(sq.size()), DATA_W'(0));
    check_eq("end_rq", DATA_W'(rq.size()), DATA_W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
